ex_stage: RTL

Registered execute stage that accepts decoded ALU instructions from the decode/issue stage over a valid/ready handshake. It resolves operands with register-file bypassing, drives the combinational `alu`, and holds the result in an output register for the writeback stage. It is the only sequential element between decode and writeback on the integer ALU path.

---
 rtl/ex_pkg.sv | 20 ++
 rtl/alu.sv | 26 ++
 rtl/ex_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, ALU opcodes and the execute-stage result record.
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] result;
    } ex_result_t;

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU; unknown opcodes produce zero.
module alu #(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    import ex_pkg::*;

    logic w_lt;

    assign w_lt = $signed(a) < $signed(b);

    always_comb begin
        y = (op == ALU_ADD) ? a + b :
            (op == ALU_SUB) ? a - b :
            (op == ALU_MUL) ? a * b :
            (op == ALU_SLL) ? a << b[4:0] :
            (op == ALU_SRL) ? a >> b[4:0] :
            (op == ALU_SLT) ? {{(DATA_W-1){1'b0}}, w_lt} :
                              '0;
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: registered execute stage with valid/ready handshake and
// operand bypassing from its own output register and the writeback port.
module ex_stage #(
    parameter int DATA_W = ex_pkg::DATA_W,
    parameter int REG_AW = ex_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_result
);
    import ex_pkg::*;

    logic              r_valid;
    ex_result_t        r_res;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_self_hit1;
    logic              w_self_hit2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_rs2;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_alu_y;

    assign in_ready   = !r_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    // The held result is the youngest value of its rd, so it wins over writeback.
    assign w_self_hit1 = r_valid && r_res.wen && (r_res.rd == in_rs1_addr);
    assign w_self_hit2 = r_valid && r_res.wen && (r_res.rd == in_rs2_addr);

    assign w_op1 = (in_rs1_addr == '0)                ? '0 :
                   w_self_hit1                        ? r_res.result :
                   (wb_wen && (wb_rd == in_rs1_addr)) ? wb_data :
                                                        in_rs1_data;
    assign w_rs2 = (in_rs2_addr == '0)                ? '0 :
                   w_self_hit2                        ? r_res.result :
                   (wb_wen && (wb_rd == in_rs2_addr)) ? wb_data :
                                                        in_rs2_data;
    assign w_op2 = in_use_imm ? in_imm : w_rs2;

    alu #(.DATA_W(DATA_W)) u_alu (
        .op (in_alu_op),
        .a  (w_op1),
        .b  (w_op2),
        .y  (w_alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_valid <= flush      ? 1'b0 :
                       w_in_fire  ? 1'b1 :
                       w_out_fire ? 1'b0 : r_valid;
            if (w_in_fire && !flush)
                r_res <= '{rd: in_rd, wen: in_wen && (in_rd != '0), result: w_alu_y};
        end
    end

    assign out_valid  = r_valid;
    assign out_rd     = r_res.rd;
    assign out_wen    = r_res.wen;
    assign out_result = r_res.result;

endmodule
